conv_loop_sequencer: RTL and testbench
======================================

# conv_loop_sequencer

Drives the convolution engine's loop nest for one layer: walks output channel, input channel, row and column indices, requests weights per (oc, ic) tile, pulses the input loader per row, and emits the 3x3 tap-valid mask per output pixel. It is the producer of the row-based dataflow signals (`dataflow_en`, `conv_vld`, `w_row`/`h_row`/`ic_row`/`oc_row`, `weight_req_row`, `input_loader_req`, `layer_start`/`layer_done`) that the utilization monitor observes. It sits between the layer controller (config plus start) and the PE array, weight buffer and input loader.

## Interface
- `DIM_W`, 16, width of every dimension config and loop index.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous and active-high.
- `layer_start`  in  1  single-cycle start pulse; sampled only in IDLE.
- `cfg_w`, `cfg_h`, `cfg_ic`, `cfg_oc`  in  DIM_W each  layer dimensions (counts); captured on accepted `layer_start`.
- `weight_ack`  in  1  weight buffer has loaded the requested (oc, ic) tile.
- `out_ready`  in  1  PE array accepts a beat this cycle.
- `dataflow_en`  out  1  high in RUN; a beat transfers when `dataflow_en & out_ready`.
- `conv_vld`  out  9  tap-valid mask for the current pixel; 0 when `dataflow_en`=0.
- `w_row`, `h_row`, `ic_row`, `oc_row`  out  DIM_W each  current loop indices.
- `weight_req_row`  out  1  level; high in WREQ until acknowledged.
- `input_loader_req`  out  1  one-cycle pulse on the first beat of each row.
- `busy`  out  1  state != IDLE.
- `layer_done`  out  1  one-cycle pulse at layer end.

## Operation
- States: IDLE, WREQ, RUN, DONE.
- IDLE: on `layer_start`, capture cfg and clear all indices. If any cfg value is 0, go to DONE. Otherwise go to WREQ.
- WREQ: `weight_req_row`=1. On `weight_ack`, go to RUN. Indices hold.
- RUN: a beat fires when `out_ready`=1. Advance order per beat:
  - w increments.
  - On w = W-1: w wraps to 0, h increments.
  - On h = H-1 as well: h wraps to 0, ic increments, go to WREQ.
  - On ic = IC-1 as well: ic wraps to 0, oc increments.
  - On oc = OC-1 as well (last beat): go to DONE, with indices returned to 0.
- When `out_ready`=0: indices, outputs and state hold.
- `conv_vld` bit k = ky*3+kx (ky, kx in 0..2; bit 0 = top-left). Bit k is 1 iff 0 <= h+ky-1 <= H-1 and 0 <= w+kx-1 <= W-1 (zero padding). Compute with DIM_W+1-bit signed arithmetic, no wrap.
- `input_loader_req` = `dataflow_en & out_ready & (w_row==0)`.
- DONE: `layer_done`=1 for one cycle, then go to IDLE.
- `layer_start` outside IDLE is ignored. `weight_ack` outside WREQ is ignored.
- `rst` in any state goes to IDLE on the next edge and drops any in-flight request.

## Timing
- Reset values: state IDLE; all indices 0; `dataflow_en`, `conv_vld`, `weight_req_row`, `input_loader_req`, `busy`, `layer_done` all 0.
- `layer_start` at cycle t gives `weight_req_row`=1 and `busy`=1 at t+1.
- `weight_ack` at cycle t in WREQ gives `dataflow_en`=1 at t+1, with the first beat presenting indices (0,0,ic,oc).
- Throughput is 1 beat/cycle with `out_ready` held high. Each (oc, ic) tile costs at least 1 WREQ cycle.
- Last beat at t gives `layer_done`=1 at t+1, and `busy`=0 at t+2.
- A zero-dimension layer gives `layer_done` at t+2 after `layer_start`, with no beats and no weight request.
- Indices and `conv_vld` are combinational from registered state, valid in the same cycle as `dataflow_en`.

## Test plan
- W=3, H=2, IC=1, OC=1, `out_ready`=1, `weight_ack` 1 cycle after request:
  - exactly 6 beats.
  - `conv_vld` at (h0,w0) = 9'h1B0, at (h1,w2) = 9'h01B.
  - 2 `input_loader_req` pulses and 1 `layer_done`.
- W=H=3: the beat at (1,1) has `conv_vld`=9'h1FF. W=H=1: the single beat has `conv_vld`=9'h010.
- W=2, H=2, IC=2, OC=3:
  - 6 weight requests, issued in order (oc,ic) = (0,0),(0,1),(1,0)…(2,1).
  - 24 beats total.
  - `weight_req_row` holds while `weight_ack` is delayed 5 cycles.
- Randomly toggle `out_ready` at 50%: the beat sequence is identical to the stall-free run, and indices hold during stalls.
- Any of `cfg_ic`=0 or the other dims 0: `layer_done` at t+2, zero beats, `weight_req_row` never asserted.
- Assert `rst` mid-RUN: next cycle all outputs are at reset values. A new `layer_start` then restarts from (0,0,0,0).

Source files
------------

// File: rtl/conv_loop_sequencer.sv
// Loop-nest sequencer for one conv layer: walks oc/ic/h/w, requests weights per tile, emits tap masks.
// Latency: start -> weight request next cycle; ack -> first beat next cycle; last beat -> layer_done next cycle.
// Backpressure: beats advance only when out_ready is high; indices, outputs and state hold otherwise.
module conv_loop_sequencer #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             layer_start,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  input  logic [DIM_W-1:0] cfg_ic,
  input  logic [DIM_W-1:0] cfg_oc,
  input  logic             weight_ack,
  input  logic             out_ready,
  output logic             dataflow_en,
  output logic [8:0]       conv_vld,
  output logic [DIM_W-1:0] w_row,
  output logic [DIM_W-1:0] h_row,
  output logic [DIM_W-1:0] ic_row,
  output logic [DIM_W-1:0] oc_row,
  output logic             weight_req_row,
  output logic             input_loader_req,
  output logic             busy,
  output logic             layer_done
);

  typedef enum logic [1:0] {IDLE, WREQ, RUN, DONE} state_t;

  localparam logic [DIM_W-1:0]        ONE    = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic signed [DIM_W:0]   OFF_M1 = '1;
  localparam logic signed [DIM_W:0]   OFF_0  = '0;
  localparam logic signed [DIM_W:0]   OFF_P1 = {{DIM_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DIM_W-1:0] w_q, h_q, ic_q, oc_q;
  logic [DIM_W-1:0] w_d, h_d, ic_d, oc_d;
  logic [DIM_W-1:0] cfg_w_q, cfg_h_q, cfg_ic_q, cfg_oc_q;
  logic             zero_q, zero_d;
  logic             cfg_load;
  logic             cfg_any_zero;
  logic             last_w, last_h, last_ic, last_oc;
  logic [2:0]       row_ok, col_ok;

  // True when idx+off lands inside [0, lim-1]; 17-bit signed so edges never wrap.
  function automatic logic tap_ok(input logic [DIM_W-1:0] idx,
                                  input logic [DIM_W-1:0] lim,
                                  input logic signed [DIM_W:0] off);
    logic signed [DIM_W:0] pos;
    logic signed [DIM_W:0] top;
    pos = $signed({1'b0, idx}) + off;
    top = $signed({1'b0, lim}) - OFF_P1;
    return !pos[DIM_W] && (pos <= top);
  endfunction

  assign cfg_any_zero = (cfg_w == '0) || (cfg_h == '0) || (cfg_ic == '0) || (cfg_oc == '0);
  assign last_w  = (w_q  == cfg_w_q  - ONE);
  assign last_h  = (h_q  == cfg_h_q  - ONE);
  assign last_ic = (ic_q == cfg_ic_q - ONE);
  assign last_oc = (oc_q == cfg_oc_q - ONE);

  assign w_row  = w_q;
  assign h_row  = h_q;
  assign ic_row = ic_q;
  assign oc_row = oc_q;
  assign busy   = (state_q != IDLE);
  assign input_loader_req = dataflow_en & out_ready & (w_q == '0);

  // State, loop indices and the zero-layer delay flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      ic_q    <= '0;
      oc_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
      zero_q  <= zero_d;
    end
  end

  // Layer dimensions, latched on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      cfg_ic_q <= '0;
      cfg_oc_q <= '0;
    end else if (cfg_load) begin
      cfg_w_q  <= cfg_w;
      cfg_h_q  <= cfg_h;
      cfg_ic_q <= cfg_ic;
      cfg_oc_q <= cfg_oc;
    end
  end

  // Next-state, index advance and control outputs.
  always_comb begin
    state_d        = state_q;
    w_d            = w_q;
    h_d            = h_q;
    ic_d           = ic_q;
    oc_d           = oc_q;
    zero_d         = zero_q;
    cfg_load       = 1'b0;
    dataflow_en    = 1'b0;
    weight_req_row = 1'b0;
    layer_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_start) begin
          cfg_load = 1'b1;
          w_d      = '0;
          h_d      = '0;
          ic_d     = '0;
          oc_d     = '0;
          if (cfg_any_zero) begin
            // Empty layer spends one extra cycle in DONE so done lands two cycles after start.
            state_d = DONE;
            zero_d  = 1'b1;
          end else begin
            state_d = WREQ;
          end
        end
      end
      WREQ: begin
        weight_req_row = 1'b1;
        if (weight_ack) state_d = RUN;
      end
      RUN: begin
        dataflow_en = 1'b1;
        if (out_ready) begin
          if (!last_w) begin
            w_d = w_q + ONE;
          end else begin
            w_d = '0;
            if (!last_h) begin
              h_d = h_q + ONE;
            end else begin
              // Tile finished: next (oc, ic) tile needs fresh weights.
              h_d     = '0;
              state_d = WREQ;
              if (!last_ic) begin
                ic_d = ic_q + ONE;
              end else begin
                ic_d = '0;
                if (!last_oc) begin
                  oc_d = oc_q + ONE;
                end else begin
                  oc_d    = '0;
                  state_d = DONE;
                end
              end
            end
          end
        end
      end
      DONE: begin
        if (zero_q) begin
          zero_d = 1'b0;
        end else begin
          layer_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // 3x3 tap mask with zero padding; bit ky*3+kx, bit 0 is top-left.
  always_comb begin
    conv_vld  = '0;
    row_ok[0] = tap_ok(h_q, cfg_h_q, OFF_M1);
    row_ok[1] = tap_ok(h_q, cfg_h_q, OFF_0);
    row_ok[2] = tap_ok(h_q, cfg_h_q, OFF_P1);
    col_ok[0] = tap_ok(w_q, cfg_w_q, OFF_M1);
    col_ok[1] = tap_ok(w_q, cfg_w_q, OFF_0);
    col_ok[2] = tap_ok(w_q, cfg_w_q, OFF_P1);
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        conv_vld[ky*3+kx] = dataflow_en & row_ok[ky] & col_ok[kx];
      end
    end
  end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
module tb_conv_loop_sequencer;

  typedef struct {
    int         oc;
    int         ic;
    int         h;
    int         w;
    logic [8:0] vld;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, layer_start, weight_ack, out_ready;
  logic [15:0] cfg_w, cfg_h, cfg_ic, cfg_oc;
  logic        dataflow_en, weight_req_row, input_loader_req, busy, layer_done;
  logic [8:0]  conv_vld;
  logic [15:0] w_row, h_row, ic_row, oc_row;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_dly = 1;
  bit rnd_ready = 0;
  bit mon_en = 0;
  bit req_prev = 0;
  int req_len = 0;
  int ack_cnt = 0;
  int n_beats, n_ilr, n_wreq, n_done;
  int last_beat_cyc = 0;
  int tstart;

  beat_t       bq[$];
  logic [31:0] wq[$];
  logic [8:0]  obs_vld[int];

  conv_loop_sequencer #(.DIM_W(16)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_ic(cfg_ic), .cfg_oc(cfg_oc),
    .weight_ack(weight_ack), .out_ready(out_ready),
    .dataflow_en(dataflow_en), .conv_vld(conv_vld),
    .w_row(w_row), .h_row(h_row), .ic_row(ic_row), .oc_row(oc_row),
    .weight_req_row(weight_req_row), .input_loader_req(input_loader_req),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference padding mask, written as explicit in-bounds tests per tap.
  function automatic logic [8:0] exp_mask(input int h, input int w, input int hh, input int ww);
    logic [8:0] m;
    m = '0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        int r, c;
        r = h + ky - 1;
        c = w + kx - 1;
        if (r >= 0 && r < hh && c >= 0 && c < ww) m[ky*3+kx] = 1'b1;
      end
    return m;
  endfunction

  // Ready and weight-ack drivers.
  initial begin
    weight_ack = 1'b0;
    out_ready  = 1'b1;
    forever begin
      tick();
      out_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      weight_ack = 1'b0;
      if (weight_req_row) begin
        ack_cnt++;
        if (ack_cnt > ack_dly) begin
          weight_ack = 1'b1;
          ack_cnt = 0;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: pops expected beats and weight requests as the DUT produces them.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (weight_req_row && !req_prev) begin
          n_wreq++;
          req_len = 1;
          if (wq.size() == 0) check("wreq_extra", 1, 0);
          else check("wreq_order", {oc_row, ic_row}, wq.pop_front());
        end else if (weight_req_row) begin
          req_len++;
        end else if (req_prev) begin
          check("wreq_hold_len", req_len, ack_dly + 1);
        end
        req_prev = weight_req_row;
        if (dataflow_en) begin
          if (bq.size() == 0) begin
            check("beat_extra", 1, 0);
          end else begin
            beat_t b;
            b = bq[0];
            check("beat", {oc_row, ic_row, h_row, w_row, conv_vld},
                  {b.oc[15:0], b.ic[15:0], b.h[15:0], b.w[15:0], b.vld});
            check("loader_req", input_loader_req, out_ready && (b.w == 0));
            if (out_ready) begin
              void'(bq.pop_front());
              n_beats++;
              obs_vld[b.h*1024 + b.w] = conv_vld;
              if (bq.size() == 0) last_beat_cyc = cyc;
            end
          end
        end else begin
          check("idle_outs", {conv_vld, input_loader_req}, 0);
        end
        if (input_loader_req) n_ilr++;
        if (layer_done) n_done++;
      end
    end
  end

  task automatic start_layer(input int ww, input int hh, input int ic, input int oc,
                             input int dly, input bit rnd, output int t);
    bit zero;
    zero = (ww == 0) || (hh == 0) || (ic == 0) || (oc == 0);
    ack_dly = dly;
    rnd_ready = rnd;
    bq.delete();
    wq.delete();
    obs_vld.delete();
    n_beats = 0; n_ilr = 0; n_wreq = 0; n_done = 0;
    if (!zero) begin
      for (int o = 0; o < oc; o++)
        for (int i = 0; i < ic; i++) begin
          wq.push_back({o[15:0], i[15:0]});
          for (int y = 0; y < hh; y++)
            for (int x = 0; x < ww; x++) begin
              beat_t b;
              b.oc = o; b.ic = i; b.h = y; b.w = x;
              b.vld = exp_mask(y, x, hh, ww);
              bq.push_back(b);
            end
        end
    end
    tick();
    cfg_w = ww[15:0]; cfg_h = hh[15:0]; cfg_ic = ic[15:0]; cfg_oc = oc[15:0];
    layer_start = 1'b1;
    t = cyc;
    tick();
    layer_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("wreq_after_start", weight_req_row, !zero);
  endtask

  task automatic finish_layer(input bit zero, input int t);
    int n;
    n = 0;
    while (!layer_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", layer_done, 1);
    if (zero) check("done_latency_zero", cyc - t, 2);
    else check("done_after_last_beat", cyc - last_beat_cyc, 1);
    check("beats_left", bq.size(), 0);
    check("wreqs_left", wq.size(), 0);
    @(negedge clk);
    check("done_pulse_busy_clear", {layer_done, busy}, 0);
    rnd_ready = 0;
  endtask

  task automatic run_layer(input int ww, input int hh, input int ic, input int oc,
                           input int dly, input bit rnd);
    int t;
    start_layer(ww, hh, ic, oc, dly, rnd, t);
    finish_layer((ww == 0) || (hh == 0) || (ic == 0) || (oc == 0), t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; layer_start = 1'b0;
    cfg_w = '0; cfg_h = '0; cfg_ic = '0; cfg_oc = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_ctrl", {dataflow_en, weight_req_row, input_loader_req, busy, layer_done}, 0);
    check("rst_vld", conv_vld, 0);
    check("rst_idx", {oc_row, ic_row, h_row, w_row}, 0);
    tick();
    rst = 1'b0;
    mon_en = 1;

    // 3x2 single tile
    run_layer(3, 2, 1, 1, 1, 0);
    check("t1_beats", n_beats, 6);
    check("t1_loader_pulses", n_ilr, 2);
    check("t1_done_pulses", n_done, 1);
    check("t1_vld_h0w0", obs_vld[0], 9'h1B0);
    check("t1_vld_h1w2", obs_vld[1*1024 + 2], 9'h01B);

    // 1x1 layer
    run_layer(1, 1, 1, 1, 1, 0);
    check("t2_beats", n_beats, 1);
    check("t2_vld", obs_vld[0], 9'h010);

    // multi-tile with slow weight ack
    run_layer(2, 2, 2, 3, 5, 0);
    check("t3_wreqs", n_wreq, 6);
    check("t3_beats", n_beats, 24);

    // same layer with random backpressure
    run_layer(2, 2, 2, 3, 1, 1);
    check("t4_beats", n_beats, 24);
    check("t4_loader_pulses", n_ilr, 12);

    // zero-dimension layers
    run_layer(0, 2, 2, 2, 1, 0);
    check("z_w_wreqs", n_wreq + n_beats, 0);
    run_layer(2, 0, 2, 2, 1, 0);
    check("z_h_wreqs", n_wreq + n_beats, 0);
    run_layer(2, 2, 0, 2, 1, 0);
    check("z_ic_wreqs", n_wreq + n_beats, 0);
    run_layer(2, 2, 2, 0, 1, 0);
    check("z_oc_wreqs", n_wreq + n_beats, 0);

    // reset in the middle of RUN, then restart
    start_layer(4, 4, 1, 1, 1, 0, tstart);
    n = 0;
    while (n_beats < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_run_reached", dataflow_en, 1);
    tick();
    mon_en = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {dataflow_en, weight_req_row, input_loader_req, busy, layer_done}, 0);
    check("rst_mid_vld", conv_vld, 0);
    check("rst_mid_idx", {oc_row, ic_row, h_row, w_row}, 0);
    req_prev = 0;
    mon_en = 1;
    run_layer(3, 3, 1, 1, 1, 0);
    check("t6_beats", n_beats, 9);
    check("t6_vld_center", obs_vld[1*1024 + 1], 9'h1FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
